// File: rtl/debug_pkg.sv
// Shared types and chain sizing for the debugger run-control unit.
package debug_pkg;

   typedef enum logic [1:0] {
      ST_HALTED = 2'd0,
      ST_RUN    = 2'd1,
      ST_STEP   = 2'd2
   } run_state_t;

   typedef enum logic [1:0] {
      CAUSE_RESET      = 2'd0,
      CAUSE_HALT_CMD   = 2'd1,
      CAUSE_BREAKPOINT = 2'd2,
      CAUSE_STEP_DONE  = 2'd3
   } halt_cause_t;

   typedef enum logic [2:0] {
      CMD_NOP  = 3'd0,
      CMD_HALT = 3'd1,
      CMD_RUN  = 3'd2,
      CMD_STEP = 3'd3
   } cmd_t;

   localparam int CMD_W = 3;

   function automatic int chain_len(input int nbp, input int aw, input int sw);
      return nbp * (aw + 1) + sw + CMD_W;
   endfunction

   // cause[1:0], pad bit, step_remaining, pc
   function automatic int status_len(input int aw, input int sw);
      return aw + sw + 3;
   endfunction

endpackage

// File: rtl/bp_compare.sv
// PC breakpoint comparators; bp_match is set when any enabled slot equals pc.
module bp_compare #(
   parameter int ADDRWIDTH = 32,
   parameter int NUM_BP    = 2
) (
   input  logic [ADDRWIDTH-1:0]             pc,
   input  logic [NUM_BP-1:0]                bp_en,
   input  logic [NUM_BP-1:0][ADDRWIDTH-1:0] bp_addr,
   output logic                             bp_match
);

   always_comb begin
      bp_match = 1'b0;
      for (int i = 0; i < NUM_BP; i++) begin
         if (bp_en[i] && (bp_addr[i] == pc)) bp_match = 1'b1;
      end
   end

endmodule

// File: rtl/debug_run_ctrl.sv
// Debugger run control: scan command chain, halt/run/step FSM and PC breakpoints
// gating the CPU clock-enable.
//
//   state      | meaning
//   ST_HALTED  | CPU frozen, oCPU_En low, cause held in oHaltCause
//   ST_RUN     | free running until HALT command or breakpoint
//   ST_STEP    | running until cnt retires have completed
module debug_run_ctrl
   import debug_pkg::*;
#(
   parameter int ADDRWIDTH    = 32,
   parameter int NUM_BP       = 2,
   parameter int STEPW        = 16,
   parameter bit RESET_HALTED = 1'b1
) (
   input  logic                 iCPU_Clk,
   input  logic                 iCPU_Reset_n,
   input  logic [ADDRWIDTH-1:0] iPC,
   input  logic                 iRetire,
   input  logic                 iScanIn,
   input  logic                 iShiftDR,
   input  logic                 iCaptureDR,
   input  logic                 iUpdateDR,
   output logic                 oScanOut,
   output logic                 oCPU_En,
   output logic                 oHalted,
   output logic [1:0]           oHaltCause
);

   localparam int CHAIN_LEN = chain_len(NUM_BP, ADDRWIDTH, STEPW);
   localparam int STAT_LEN  = status_len(ADDRWIDTH, STEPW);
   localparam int BP_BASE   = CMD_W + STEPW;
   localparam run_state_t RST_STATE = RESET_HALTED ? ST_HALTED : ST_RUN;

   run_state_t  state_q, state_d;
   halt_cause_t cause_q, cause_d;
   logic [STEPW-1:0]                cnt_q, cnt_d;
   logic                            skip_q, skip_d;
   logic [CHAIN_LEN-1:0]            sr_q, sr_d;
   logic [NUM_BP-1:0]               bp_en_q, bp_en_d;
   logic [NUM_BP-1:0][ADDRWIDTH-1:0] bp_addr_q, bp_addr_d;

   logic [CHAIN_LEN-1:0]             status;
   logic [2:0]                       cmd;
   logic [STEPW-1:0]                 cmd_step;
   logic [NUM_BP-1:0]                cmd_bp_en;
   logic [NUM_BP-1:0][ADDRWIDTH-1:0] cmd_bp_addr;
   logic                             cmd_valid;
   logic                             bp_match, bp_hit, cpu_en, retire_en;

   bp_compare #(
      .ADDRWIDTH (ADDRWIDTH),
      .NUM_BP    (NUM_BP)
   ) u_bp_compare (
      .pc       (iPC),
      .bp_en    (bp_en_q),
      .bp_addr  (bp_addr_q),
      .bp_match (bp_match)
   );

   // skip masks the breakpoint at the resume PC until its instruction retires
   assign bp_hit    = (state_q != ST_HALTED) && !skip_q && bp_match;
   assign cpu_en    = (state_q != ST_HALTED) && !bp_hit;
   assign retire_en = iRetire && cpu_en;

   always_comb begin
      cmd      = sr_q[CMD_W-1:0];
      cmd_step = sr_q[CMD_W +: STEPW];
      for (int i = 0; i < NUM_BP; i++) begin
         cmd_bp_en[i]   = sr_q[BP_BASE + i*(ADDRWIDTH+1)];
         cmd_bp_addr[i] = sr_q[BP_BASE + i*(ADDRWIDTH+1) + 1 +: ADDRWIDTH];
      end
      cmd_valid = (cmd == CMD_HALT) || (cmd == CMD_RUN) || (cmd == CMD_STEP);
   end

   always_comb begin
      status                          = '0;
      status[1:0]                     = cause_q;
      status[CMD_W +: STEPW]          = cnt_q;
      status[CMD_W+STEPW +: ADDRWIDTH] = iPC;
   end

   always_comb begin
      state_d   = state_q;
      cause_d   = cause_q;
      cnt_d     = cnt_q;
      skip_d    = skip_q;
      sr_d      = sr_q;
      bp_en_d   = bp_en_q;
      bp_addr_d = bp_addr_q;

      if (retire_en) skip_d = 1'b0;

      if (bp_hit) begin
         state_d = ST_HALTED;
         cause_d = CAUSE_BREAKPOINT;
      end else if ((state_q == ST_STEP) && retire_en) begin
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == STEPW'(1)) begin
            state_d = ST_HALTED;
            cause_d = CAUSE_STEP_DONE;
         end
      end

      // a command applied this cycle overrides the internal event above
      if (iCaptureDR) begin
         sr_d = status;
      end else if (iUpdateDR) begin
         if (cmd_valid) begin
            bp_en_d   = cmd_bp_en;
            bp_addr_d = cmd_bp_addr;
         end
         case (cmd)
            CMD_HALT: begin
               state_d = ST_HALTED;
               cause_d = CAUSE_HALT_CMD;
            end
            CMD_RUN: begin
               state_d = ST_RUN;
               skip_d  = 1'b1;
            end
            CMD_STEP: begin
               if (cmd_step != '0) begin
                  state_d = ST_STEP;
                  cnt_d   = cmd_step;
                  skip_d  = 1'b1;
               end else begin
                  state_d = ST_HALTED;
                  cause_d = CAUSE_STEP_DONE;
               end
            end
            default: ;
         endcase
      end else if (iShiftDR) begin
         sr_d = {iScanIn, sr_q[CHAIN_LEN-1:1]};
      end
   end

   always_ff @(posedge iCPU_Clk or negedge iCPU_Reset_n) begin
      if (!iCPU_Reset_n) begin
         state_q   <= RST_STATE;
         cause_q   <= CAUSE_RESET;
         cnt_q     <= '0;
         skip_q    <= 1'b0;
         sr_q      <= '0;
         bp_en_q   <= '0;
         bp_addr_q <= '0;
      end else begin
         state_q   <= state_d;
         cause_q   <= cause_d;
         cnt_q     <= cnt_d;
         skip_q    <= skip_d;
         sr_q      <= sr_d;
         bp_en_q   <= bp_en_d;
         bp_addr_q <= bp_addr_d;
      end
   end

   assign oScanOut   = sr_q[0];
   assign oCPU_En    = cpu_en;
   assign oHalted    = (state_q == ST_HALTED);
   assign oHaltCause = cause_q;

   if (STAT_LEN > CHAIN_LEN) begin : g_bad_len
      $error("status does not fit in the scan chain");
   end

endmodule

// File: tb/tb_debug_run_ctrl.sv
// Directed bench for debug_run_ctrl with default parameters (85-bit chain).
module tb_debug_run_ctrl;

   logic        iCPU_Clk = 1'b0;
   logic        iCPU_Reset_n = 1'b1;
   logic [31:0] iPC = 32'h0;
   logic        iRetire = 1'b0;
   logic        iScanIn = 1'b0;
   logic        iShiftDR = 1'b0;
   logic        iCaptureDR = 1'b0;
   logic        iUpdateDR = 1'b0;
   logic        oScanOut, oCPU_En, oHalted;
   logic [1:0]  oHaltCause;

   int          errs = 0;
   int          checks = 0;
   logic [84:0] rd;
   int          n, k;

   localparam logic [2:0] C_HALT = 3'd1, C_RUN = 3'd2, C_STEP = 3'd3;

   debug_run_ctrl dut (
      .iCPU_Clk     (iCPU_Clk),
      .iCPU_Reset_n (iCPU_Reset_n),
      .iPC          (iPC),
      .iRetire      (iRetire),
      .iScanIn      (iScanIn),
      .iShiftDR     (iShiftDR),
      .iCaptureDR   (iCaptureDR),
      .iUpdateDR    (iUpdateDR),
      .oScanOut     (oScanOut),
      .oCPU_En      (oCPU_En),
      .oHalted      (oHalted),
      .oHaltCause   (oHaltCause)
   );

   always #5 iCPU_Clk = ~iCPU_Clk;

   task automatic check(input string tag, input logic [84:0] got, input logic [84:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [84:0] mk(input logic [2:0] c, input logic [15:0] s,
                                      input logic e0, input logic [31:0] a0);
      return {32'h0, 1'b0, a0, e0, s, c};
   endfunction

   function automatic logic [84:0] stat(input logic [1:0] cause, input logic [15:0] cnt,
                                        input logic [31:0] pc);
      return {34'h0, pc, cnt, 1'b0, cause};
   endfunction

   // one clock; the bench CPU advances its PC by 4 on every enabled retire
   task automatic cyc();
      logic en_s;
      #1;
      en_s = oCPU_En && iRetire;
      @(posedge iCPU_Clk);
      #1;
      if (en_s) iPC = iPC + 32'd4;
      #1;
   endtask

   task automatic scan(input logic [84:0] v, output logic [84:0] r);
      for (int i = 0; i < 85; i++) begin
         r[i]     = oScanOut;
         iScanIn  = v[i];
         iShiftDR = 1'b1;
         cyc();
      end
      iShiftDR = 1'b0;
      iScanIn  = 1'b0;
   endtask

   task automatic update();
      iUpdateDR = 1'b1;
      cyc();
      iUpdateDR = 1'b0;
   endtask

   task automatic capture();
      iCaptureDR = 1'b1;
      cyc();
      iCaptureDR = 1'b0;
   endtask

   initial begin
      // reset
      iPC = 32'h100;
      #3 iCPU_Reset_n = 1'b0;
      #1;
      check("rst_halted", oHalted, 1);
      check("rst_cpu_en", oCPU_En, 0);
      check("rst_cause", oHaltCause, 0);
      check("rst_scanout", oScanOut, 0);
      cyc(); cyc();
      iCPU_Reset_n = 1'b1;
      cyc();
      capture();
      scan('0, rd);
      check("rst_status", rd, stat(2'd0, 16'd0, 32'h100));

      // run / halt commands
      iPC = 32'h0;
      iRetire = 1'b1;
      scan(mk(C_RUN, 16'd0, 1'b0, 32'h0), rd);
      check("run_pre_en", oCPU_En, 0);
      update();
      check("run_en", oCPU_En, 1);
      check("run_halted", oHalted, 0);
      cyc(); cyc(); cyc();
      check("run_pc", iPC, 32'hC);
      scan(mk(C_HALT, 16'd0, 1'b0, 32'h0), rd);
      update();
      check("halt_en", oCPU_En, 0);
      check("halt_cause", oHaltCause, 1);

      // breakpoint at 0x10
      iPC = 32'h0;
      scan(mk(C_RUN, 16'd0, 1'b1, 32'h10), rd);
      update();
      check("bp_run_en", oCPU_En, 1);
      k = 0;
      while (oCPU_En && k < 20) begin
         cyc();
         k++;
      end
      check("bp_wait", (k < 20), 1);
      check("bp_pc", iPC, 32'h10);
      check("bp_comb_drop", oHalted, 0);
      cyc();
      check("bp_halted", oHalted, 1);
      check("bp_cause", oHaltCause, 2);
      check("bp_pc_hold", iPC, 32'h10);
      scan(mk(C_RUN, 16'd0, 1'b1, 32'h10), rd);
      update();
      check("bp_resume_en", oCPU_En, 1);
      cyc();
      check("bp_resume_pc", iPC, 32'h14);
      check("bp_resume_run", oCPU_En, 1);
      scan(mk(C_HALT, 16'd0, 1'b0, 32'h0), rd);
      update();
      check("bp_halt2", oHalted, 1);

      // step 3
      scan(mk(C_STEP, 16'd3, 1'b0, 32'h0), rd);
      update();
      n = 0;
      k = 0;
      while (!oHalted && k < 20) begin
         if (oCPU_En) n++;
         cyc();
         k++;
      end
      check("step3_count", n, 3);
      check("step3_halted", oHalted, 1);
      check("step3_cause", oHaltCause, 3);
      capture();
      scan('0, rd);
      check("step3_status", rd, stat(2'd3, 16'd0, iPC));

      // update HALT in the same cycle as a breakpoint hit
      iRetire = 1'b0;
      iPC = 32'h3C;
      scan(mk(C_RUN, 16'd0, 1'b1, 32'h40), rd);
      update();
      check("race_run_en", oCPU_En, 1);
      scan(mk(C_HALT, 16'd0, 1'b1, 32'h40), rd);
      check("race_frozen_pc", iPC, 32'h3C);
      iRetire = 1'b1;
      cyc();
      iRetire = 1'b0;
      check("race_bp_hit", oCPU_En, 0);
      update();
      check("race_halted", oHalted, 1);
      check("race_cause", oHaltCause, 1);

      // step 0
      scan(mk(C_STEP, 16'd0, 1'b0, 32'h0), rd);
      update();
      check("step0_halted", oHalted, 1);
      check("step0_cause", oHaltCause, 3);

      // capture and update together: capture wins, command ignored
      scan(mk(C_RUN, 16'd0, 1'b0, 32'h0), rd);
      iCaptureDR = 1'b1;
      iUpdateDR  = 1'b1;
      cyc();
      iCaptureDR = 1'b0;
      iUpdateDR  = 1'b0;
      check("capupd_halted", oHalted, 1);
      scan('0, rd);
      check("capupd_status", rd, stat(2'd3, 16'd0, 32'h40));

      // async reset mid-step (cnt=5) and mid-shift
      iRetire = 1'b1;
      scan(mk(C_STEP, 16'd10, 1'b1, 32'h0), rd);
      update();
      for (int i = 0; i < 5; i++) cyc();
      iRetire = 1'b0;
      check("mid_step_running", oHalted, 0);
      iScanIn  = 1'b1;
      iShiftDR = 1'b1;
      for (int i = 0; i < 90; i++) cyc();
      check("mid_shift_out", oScanOut, 1);
      #2 iCPU_Reset_n = 1'b0;
      #1;
      check("arst_halted", oHalted, 1);
      check("arst_cpu_en", oCPU_En, 0);
      check("arst_cause", oHaltCause, 0);
      check("arst_scanout", oScanOut, 0);
      cyc();
      iShiftDR = 1'b0;
      iScanIn  = 1'b0;
      iCPU_Reset_n = 1'b1;
      cyc();
      scan('0, rd);
      check("arst_sr", rd, '0);
      capture();
      scan('0, rd);
      check("arst_status", rd, stat(2'd0, 16'd0, iPC));

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/debug_run_ctrl.md
Name: debug_run_ctrl

Overview:
- Parametrised run-control unit that sits between the on-board debugger scan interface and the CPU core.
- Gates CPU progress through a clock-enable (oCPU_En, driving PC-register Load and all architectural writes).
- Provides halt, run, N-instruction step and NUM_BP hardware PC breakpoints, all programmed through a serial command chain.
- Generalises the fixed oFetch=1 debug hook into real run control.

Parameters:
ADDRWIDTH, 32, PC / breakpoint address width
NUM_BP, 2, number of PC breakpoint comparators (>=1)
STEPW, 16, width of step counter
RESET_HALTED, 1, 1: leave reset in HALTED; 0: leave reset in RUN

Ports:
iCPU_Clk  input  1  sole clock, rising edge
iCPU_Reset_n  input  1  asynchronous, active-low reset
iPC  input  ADDRWIDTH  PC of instruction about to execute
iRetire  input  1  CPU completes one instruction this cycle (only meaningful when oCPU_En=1)
iScanIn  input  1  serial data from debugger
iShiftDR  input  1  synchronous shift strobe
iCaptureDR  input  1  synchronous capture strobe
iUpdateDR  input  1  synchronous update (command apply) strobe
oScanOut  output  1  serial data to debugger, = SR[0]
oCPU_En  output  1  CPU may advance this cycle
oHalted  output  1  state == HALTED
oHaltCause  output  2  0 RESET, 1 HALT_CMD, 2 BREAKPOINT, 3 STEP_DONE

Behaviour:
- CHAIN_LEN = NUM_BP*(ADDRWIDTH+1)+STEPW+3; shift register SR[CHAIN_LEN-1:0]. Default CHAIN_LEN is 85.
- Command layout, LSB first: cmd[2:0], step_count[STEPW], then per bp i = 0..NUM_BP-1: en_i, addr_i[ADDRWIDTH].
- Status layout (capture), LSB first: cause[1:0], 0, step_remaining[STEPW], iPC[ADDRWIDTH], remaining bits zero.
- Strobe priority in one cycle: Capture > Update > Shift.
  - Capture: SR <= status.
  - Shift: SR <= {iScanIn, SR[CHAIN_LEN-1:1]}.
  - Update: decode SR as command. Every non-NOP command also latches all bp en/addr fields.
- cmd encodings: 000 NOP, 001 HALT, 010 RUN, 011 STEP, others treated as NOP (bp fields not latched).
- FSM states: HALTED, RUN, STEP.
  - HALT: any state -> HALTED, cause HALT_CMD.
  - RUN: -> RUN, skip <= 1.
  - STEP with step_count != 0: -> STEP, cnt <= step_count, skip <= 1.
  - STEP with step_count == 0: -> HALTED, cause STEP_DONE.
- bp_hit (combinational) = state != HALTED, !skip, and any en_i with addr_i == iPC.
- oCPU_En = (state != HALTED) && !bp_hit. Combinational, so the breakpointed instruction never executes.
- Cycle with bp_hit and no Update: next state HALTED, cause BREAKPOINT. cnt is unchanged.
- skip clears on the first iRetire after resume. This lets a resume from a breakpoint PC execute that instruction once.
- STEP: each iRetire with oCPU_En=1 decrements cnt. On a retire with cnt == 1 -> HALTED, cause STEP_DONE. That retire cycle is the last enabled cycle.
- Update command beats a same-cycle internal event (bp_hit or step completion); the command's result wins.
- iRetire while oCPU_En=0 is ignored.
- Reset (async, any time, including mid-shift or mid-step):
  - SR = 0, all en_i = 0, addr_i = 0, cnt = 0, skip = 0, cause = RESET.
  - State = HALTED if RESET_HALTED else RUN.
  - Outputs during reset: oScanOut=0, oHalted=RESET_HALTED, oCPU_En=!RESET_HALTED.

Decomposition:
- Package debug_pkg: run_state_t enum, halt_cause_t, cmd_t encodings, CHAIN_LEN / status-length functions.
- Sub-module bp_compare: NUM_BP equality comparators plus enable OR, output bp_match.

Test Plan:
- Reset with RESET_HALTED=1 -> oHalted=1, oCPU_En=0, oHaltCause=0. Then capture and shift 85 bits -> status reads cause=0 and iPC.
- Shift RUN (cmd=010, bps disabled), Update -> oCPU_En=1 next cycle. Later HALT command -> oCPU_En=0 the cycle after Update, cause=1.
- bp0 = 0x0000_0010 enabled, RUN from PC 0x0 with one retire per cycle:
  - -> oCPU_En drops combinationally when iPC=0x10; oHalted=1, cause=2.
  - Re-issue RUN -> instruction at 0x10 retires once, execution continues to 0x14.
- STEP with step_count=3 -> exactly 3 enabled retire cycles, then HALTED, cause=3, captured step_remaining=0. STEP with step_count=0 -> immediate HALTED, cause=3.
- Same-cycle Update(HALT) with bp hit -> cause=1, not 2. Same-cycle Capture and Update -> SR loaded with status, no command applied.
- Assert iCPU_Reset_n=0 mid-STEP (cnt=5) and mid-shift -> all state cleared asynchronously, breakpoints disabled, cause=0.
